// File: rtl/imem_responder_if.sv
// Fetch <-> instruction-memory bus: PC request/response channels, flush, and the program-load write port.
// master = fetch stage / loader side, slave = responder side.
interface imem_responder_if #(
  parameter int DWIDTH = 32
);
  logic              req_valid_fi;
  logic [DWIDTH-1:0] req_addr_fi;
  logic              req_ready_fo;
  logic              flush_fi;
  logic              rsp_valid_fo;
  logic              rsp_ready_fi;
  logic [DWIDTH-1:0] rsp_instr_fo;
  logic [DWIDTH-1:0] rsp_pc_fo;
  logic              rsp_fault_fo;
  logic              load_we_fi;
  logic [DWIDTH-1:0] load_addr_fi;
  logic [DWIDTH-1:0] load_data_fi;

  modport master (
    output req_valid_fi, req_addr_fi, flush_fi, rsp_ready_fi,
           load_we_fi, load_addr_fi, load_data_fi,
    input  req_ready_fo, rsp_valid_fo, rsp_instr_fo, rsp_pc_fo, rsp_fault_fo
  );

  modport slave (
    input  req_valid_fi, req_addr_fi, flush_fi, rsp_ready_fi,
           load_we_fi, load_addr_fi, load_data_fi,
    output req_ready_fo, rsp_valid_fo, rsp_instr_fo, rsp_pc_fo, rsp_fault_fo
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder with program-load port; IMEM_FAULT_EN adds misaligned/out-of-range faults.
// Latency: request accepted in cycle N is visible in cycle N+LATENCY when the response queue is empty.
// Backpressure: at most RSP_DEPTH outstanding; req_ready drops when full unless a pop or flush frees a slot.
module imem_responder #(
  parameter int DWIDTH    = 32,
  parameter int MEM_SIZE  = 16384,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input logic             Clk_Core,
  input logic             Rst_Core,
  imem_responder_if.slave bus
);
  localparam int AW    = $clog2(MEM_SIZE);
  localparam int WORDS = MEM_SIZE / 4;
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h0000_0013);

  logic [DWIDTH-1:0] mem [WORDS];

  logic              accept;
  logic              pop;
  logic              flush;
  logic              req_rdy;
  logic              rsp_vld;
  logic [CW-1:0]     out_cnt;
  logic [AW-3:0]     rd_idx;
  logic [AW-3:0]     ld_idx;
  logic [DWIDTH-1:0] rd_word;
  logic              rd_fault;
  logic              ld_en;

  logic              enq_vld;
  logic              enq_fault;
  logic [DWIDTH-1:0] enq_pc;
  logic [DWIDTH-1:0] enq_word;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     q_cnt;
  logic [DWIDTH-1:0] q_pc   [2**PW];
  logic [DWIDTH-1:0] q_word [2**PW];
  logic [2**PW-1:0]  q_fault;

  assign flush  = bus.flush_fi;
  assign rd_idx = bus.req_addr_fi[AW-1:2];
  assign ld_idx = bus.load_addr_fi[AW-1:2];

`ifdef IMEM_FAULT_EN
  logic unused_ld_bits;
  assign rd_fault = (bus.req_addr_fi[1:0] != 2'b00) || (|bus.req_addr_fi[DWIDTH-1:AW]);
  assign rd_word  = rd_fault ? NOP : mem[rd_idx];
  assign ld_en    = bus.load_we_fi && !(|bus.load_addr_fi[DWIDTH-1:AW]);
  assign unused_ld_bits = ^bus.load_addr_fi[1:0];
`else
  // Addresses wrap modulo MEM_SIZE; byte-offset and high bits are don't-care.
  logic unused_addr_bits;
  assign rd_fault = 1'b0;
  assign rd_word  = mem[rd_idx];
  assign ld_en    = bus.load_we_fi;
  assign unused_addr_bits = ^{bus.req_addr_fi[DWIDTH-1:AW], bus.req_addr_fi[1:0],
                              bus.load_addr_fi[DWIDTH-1:AW], bus.load_addr_fi[1:0], q_fault};
`endif

  // Array read happens at accept, so a same-cycle load is seen only by later requests.
  always_ff @(posedge Clk_Core) begin
    if (ld_en) begin
      mem[ld_idx] <= bus.load_data_fi;
    end
  end

  assign pop     = rsp_vld & bus.rsp_ready_fi;
  assign req_rdy = flush | (out_cnt < CW'(RSP_DEPTH)) | pop;
  assign accept  = bus.req_valid_fi & req_rdy;
  assign bus.req_ready_fo = req_rdy;

  // The redirect target accepted alongside a flush survives as the only outstanding entry.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      out_cnt <= '0;
    end else if (flush) begin
      out_cnt <= CW'(accept);
    end else if (accept && !pop) begin
      out_cnt <= out_cnt + CW'(1);
    end else if (pop && !accept) begin
      out_cnt <= out_cnt - CW'(1);
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign enq_vld   = accept;
      assign enq_pc    = bus.req_addr_fi;
      assign enq_word  = rd_word;
      assign enq_fault = rd_fault;
    end else begin : g_pipe
      localparam int PL = LATENCY - 1;
      logic [PL-1:0]     p_vld;
      logic [PL-1:0]     p_fault;
      logic [DWIDTH-1:0] p_pc   [PL];
      logic [DWIDTH-1:0] p_word [PL];

      always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
          p_vld <= '0;
        end else begin
          p_vld[0] <= accept;
          for (int i = 1; i < PL; i++) begin
            p_vld[i] <= p_vld[i-1] & ~flush;
          end
        end
      end

      always_ff @(posedge Clk_Core) begin
        p_pc[0]    <= bus.req_addr_fi;
        p_word[0]  <= rd_word;
        p_fault[0] <= rd_fault;
        for (int i = 1; i < PL; i++) begin
          p_pc[i]    <= p_pc[i-1];
          p_word[i]  <= p_word[i-1];
          p_fault[i] <= p_fault[i-1];
        end
      end

      // An entry leaving the pipe on a flush edge is stale and must not reach the queue.
      assign enq_vld   = p_vld[PL-1] & ~flush;
      assign enq_pc    = p_pc[PL-1];
      assign enq_word  = p_word[PL-1];
      assign enq_fault = p_fault[PL-1];
    end
  endgenerate

  // Flush empties the queue by snapping the read pointer onto the write pointer.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + PW'(enq_vld);
      q_cnt  <= CW'(enq_vld);
    end else begin
      wr_ptr <= wr_ptr + PW'(enq_vld);
      rd_ptr <= rd_ptr + PW'(pop);
      q_cnt  <= q_cnt + CW'(enq_vld) - CW'(pop);
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (enq_vld) begin
      q_pc[wr_ptr]    <= enq_pc;
      q_word[wr_ptr]  <= enq_word;
      q_fault[wr_ptr] <= enq_fault;
    end
  end

  assign rsp_vld          = (q_cnt != '0);
  assign bus.rsp_valid_fo = rsp_vld;
  assign bus.rsp_instr_fo = rsp_vld ? q_word[rd_ptr] : NOP;
  assign bus.rsp_pc_fo    = rsp_vld ? q_pc[rd_ptr] : '0;
`ifdef IMEM_FAULT_EN
  assign bus.rsp_fault_fo = rsp_vld & q_fault[rd_ptr];
`else
  assign bus.rsp_fault_fo = 1'b0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: ordering, backpressure, flush, reset, load collision, fault/wrap.
module tb_imem_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W4  = 32'h0010_8113;
  localparam logic [31:0] W8  = 32'h1111_1111;
  localparam logic [31:0] W40 = 32'hCAFE_0040;
  localparam logic [31:0] WDB = 32'hDEAD_BEEF;

  logic Clk_Core = 1'b0;
  logic Rst_Core;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] t2_pc [6];

  imem_responder_if #(.DWIDTH(32)) bus ();

  imem_responder #(.DWIDTH(32), .MEM_SIZE(16384), .LATENCY(2), .RSP_DEPTH(4)) dut (
    .Clk_Core (Clk_Core),
    .Rst_Core (Rst_Core),
    .bus      (bus.slave)
  );

  always #5 Clk_Core = ~Clk_Core;

  task automatic tick();
    @(posedge Clk_Core);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk_Core);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    case (pc)
      32'h0:   return W0;
      32'h4:   return W4;
      32'h8:   return W8;
      default: return W40;
    endcase
  endfunction

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.load_we_fi   = 1'b1;
    bus.load_addr_fi = a;
    bus.load_data_fi = d;
    tick();
    bus.load_we_fi   = 1'b0;
  endtask

  initial begin
    Rst_Core         = 1'b1;
    bus.req_valid_fi = 1'b0;
    bus.req_addr_fi  = '0;
    bus.flush_fi     = 1'b0;
    bus.rsp_ready_fi = 1'b0;
    bus.load_we_fi   = 1'b0;
    bus.load_addr_fi = '0;
    bus.load_data_fi = '0;
    t2_pc[0] = 32'h0; t2_pc[1] = 32'h4; t2_pc[2] = 32'h8;
    t2_pc[3] = 32'h0; t2_pc[4] = 32'h4; t2_pc[5] = 32'h8;
    repeat (3) tick();
    Rst_Core = 1'b0;

    // Reset state
    mid();
    chk1("rst_valid", bus.rsp_valid_fo, 1'b0);
    chk ("rst_instr", bus.rsp_instr_fo, NOP);
    chk ("rst_pc",    bus.rsp_pc_fo, 32'h0);
    chk1("rst_fault", bus.rsp_fault_fo, 1'b0);
    chk1("rst_ready", bus.req_ready_fo, 1'b1);
    tick();

    load(32'h0,  W0);
    load(32'h4,  W4);
    load(32'h8,  W8);
    load(32'h40, W40);

    // 1: back-to-back requests, responses at +2 with no bubble
    bus.rsp_ready_fi = 1'b1;
    bus.req_valid_fi = 1'b1;
    bus.req_addr_fi  = 32'h0;
    mid(); chk1("t1_ready0", bus.req_ready_fo, 1'b1);
    tick();
    bus.req_addr_fi  = 32'h4;
    mid(); chk1("t1_valid_early", bus.rsp_valid_fo, 1'b0);
    tick();
    bus.req_valid_fi = 1'b0;
    mid();
    chk1("t1_valid_a", bus.rsp_valid_fo, 1'b1);
    chk ("t1_instr_a", bus.rsp_instr_fo, W0);
    chk ("t1_pc_a",    bus.rsp_pc_fo, 32'h0);
    tick();
    mid();
    chk1("t1_valid_b", bus.rsp_valid_fo, 1'b1);
    chk ("t1_instr_b", bus.rsp_instr_fo, W4);
    chk ("t1_pc_b",    bus.rsp_pc_fo, 32'h4);
    tick();
    mid();
    chk1("t1_idle_valid", bus.rsp_valid_fo, 1'b0);
    chk ("t1_idle_instr", bus.rsp_instr_fo, NOP);
    tick();

    // 2: stalled consumer, ready drops after 4 accepts, outputs hold
    bus.rsp_ready_fi = 1'b0;
    bus.req_valid_fi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr_fi = t2_pc[i];
      mid(); chk1("t2_accept_ready", bus.req_ready_fo, 1'b1);
      tick();
    end
    bus.req_addr_fi = t2_pc[4];
    for (int i = 0; i < 2; i++) begin
      mid();
      chk1("t2_full_ready", bus.req_ready_fo, 1'b0);
      chk1("t2_hold_valid", bus.rsp_valid_fo, 1'b1);
      chk ("t2_hold_pc",    bus.rsp_pc_fo, t2_pc[0]);
      chk ("t2_hold_instr", bus.rsp_instr_fo, W0);
      tick();
    end
    bus.rsp_ready_fi = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) bus.req_addr_fi = t2_pc[5];
      if (k == 2) bus.req_valid_fi = 1'b0;
      mid();
      if (k < 2) chk1("t2_pop_ready", bus.req_ready_fo, 1'b1);
      chk1("t2_drain_valid", bus.rsp_valid_fo, 1'b1);
      chk ("t2_drain_pc",    bus.rsp_pc_fo, t2_pc[k]);
      chk ("t2_drain_instr", bus.rsp_instr_fo, word_at(t2_pc[k]));
      tick();
    end
    mid(); chk1("t2_empty", bus.rsp_valid_fo, 1'b0);
    tick();

    // 3: flush with a full queue keeps only the redirect target; count restarts at 1
    bus.rsp_ready_fi = 1'b0;
    bus.req_valid_fi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr_fi = t2_pc[i];
      tick();
    end
    bus.req_addr_fi = 32'h40;
    mid(); chk1("t3_full_ready", bus.req_ready_fo, 1'b0);
    tick();
    bus.flush_fi = 1'b1;
    mid(); chk1("t3_flush_ready", bus.req_ready_fo, 1'b1);
    tick();
    bus.flush_fi = 1'b0;
    mid();
    chk1("t3_post_flush_valid", bus.rsp_valid_fo, 1'b0);
    chk1("t3_ready_c1", bus.req_ready_fo, 1'b1);
    tick();
    mid();
    chk1("t3_target_valid", bus.rsp_valid_fo, 1'b1);
    chk ("t3_target_pc",    bus.rsp_pc_fo, 32'h40);
    chk ("t3_target_instr", bus.rsp_instr_fo, W40);
    chk1("t3_ready_c2", bus.req_ready_fo, 1'b1);
    tick();
    mid(); chk1("t3_ready_c3", bus.req_ready_fo, 1'b1);
    tick();
    mid(); chk1("t3_ready_full", bus.req_ready_fo, 1'b0);
    tick();
    bus.req_valid_fi = 1'b0;
    bus.rsp_ready_fi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk1("t3_drain_valid", bus.rsp_valid_fo, 1'b1);
      chk ("t3_drain_pc",    bus.rsp_pc_fo, 32'h40);
      tick();
    end
    mid(); chk1("t3_empty", bus.rsp_valid_fo, 1'b0);
    tick();

    // 4: reset with two outstanding discards them
    bus.rsp_ready_fi = 1'b0;
    bus.req_valid_fi = 1'b1;
    bus.req_addr_fi  = 32'h0;
    tick();
    bus.req_addr_fi  = 32'h4;
    tick();
    bus.req_valid_fi = 1'b0;
    mid(); chk1("t4_pre_valid", bus.rsp_valid_fo, 1'b1);
    Rst_Core = 1'b1;
    tick();
    Rst_Core = 1'b0;
    bus.rsp_ready_fi = 1'b1;
    mid();
    chk1("t4_valid", bus.rsp_valid_fo, 1'b0);
    chk ("t4_instr", bus.rsp_instr_fo, NOP);
    chk ("t4_pc",    bus.rsp_pc_fo, 32'h0);
    chk1("t4_ready", bus.req_ready_fo, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      mid(); chk1("t4_no_stale", bus.rsp_valid_fo, 1'b0);
    end
    tick();

    // 5: load and read of the same word in one cycle returns the old word
    bus.load_we_fi   = 1'b1;
    bus.load_addr_fi = 32'h8;
    bus.load_data_fi = WDB;
    bus.req_valid_fi = 1'b1;
    bus.req_addr_fi  = 32'h8;
    mid(); chk1("t5_ready", bus.req_ready_fo, 1'b1);
    tick();
    bus.load_we_fi   = 1'b0;
    tick();
    bus.req_valid_fi = 1'b0;
    mid();
    chk ("t5_old_pc",    bus.rsp_pc_fo, 32'h8);
    chk ("t5_old_instr", bus.rsp_instr_fo, W8);
    tick();
    mid();
    chk ("t5_new_instr", bus.rsp_instr_fo, WDB);
    tick();

    // 6: misaligned and out-of-range PCs
    bus.req_valid_fi = 1'b1;
    bus.req_addr_fi  = 32'h2;
    tick();
    bus.req_addr_fi  = 32'h4000;
    tick();
    bus.req_valid_fi = 1'b0;
    mid();
    chk("t6_pc_mis", bus.rsp_pc_fo, 32'h2);
`ifdef IMEM_FAULT_EN
    chk1("t6_fault_mis", bus.rsp_fault_fo, 1'b1);
    chk ("t6_instr_mis", bus.rsp_instr_fo, NOP);
`else
    chk1("t6_fault_mis", bus.rsp_fault_fo, 1'b0);
    chk ("t6_instr_mis", bus.rsp_instr_fo, W0);
`endif
    tick();
    mid();
    chk("t6_pc_oor", bus.rsp_pc_fo, 32'h4000);
`ifdef IMEM_FAULT_EN
    chk1("t6_fault_oor", bus.rsp_fault_fo, 1'b1);
    chk ("t6_instr_oor", bus.rsp_instr_fo, NOP);
`else
    chk1("t6_fault_oor", bus.rsp_fault_fo, 1'b0);
    chk ("t6_instr_oor", bus.rsp_instr_fo, W0);
`endif
    tick();
    mid(); chk1("t6_empty", bus.rsp_valid_fo, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
